ula_seq: RTL and testbench



---
 rtl/ula_pkg.sv | 34 +++
 rtl/ula_seq_muldiv.sv | 80 ++++++++
 rtl/ula_seq.sv | 171 +++++++++++++++++
 tb/tb_ula_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ULA: opcode map, flag bit positions,
// FSM state encoding and opcode classification.
package ula_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_MOD  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_XNOR = 4'b1100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcodes served by the iterative shift-based unit.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ula_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider sharing one
// WIDTH+1 adder and one 2*WIDTH shift register; one iteration per clock.
module ula_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] sr_q;
  logic [2*WIDTH-1:0] sr_next;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     add_sum;
  logic               add_cin;

  // The upper half is the accumulator (MUL) or partial remainder (DIV); the
  // lower half shifts out multiplier bits or shifts in quotient bits.
  always_comb begin
    if (is_div_q) begin
      add_x   = sr_q[2*WIDTH-1:WIDTH-1];
      add_y   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, sr_q[2*WIDTH-1:WIDTH]};
      add_y   = sr_q[0] ? {1'b0, b_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

    if (!is_div_q)
      sr_next = {add_sum, sr_q[WIDTH-1:1]};
    else if (!add_sum[WIDTH])
      sr_next = {add_sum[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
    else
      sr_next = {sr_q[2*WIDTH-2:0], 1'b0};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      sr_q     <= {{WIDTH{1'b0}}, a};
      b_q      <= b;
      is_div_q <= is_div;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      sr_q  <= sr_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Outputs expose the value after the current iteration so the parent can
  // register the final answer on the same edge as the last step.
  assign done       = (cnt_q == CNT_W'(1));
  assign product_hi = sr_next[2*WIDTH-1:WIDTH];
  assign product_lo = sr_next[WIDTH-1:0];
  assign remainder  = sr_next[2*WIDTH-1:WIDTH];
  assign quotient   = sr_next[WIDTH-1:0];

endmodule

// File: rtl/ula_seq.sv
// Handshaked WIDTH-bit ULA: single-cycle add/sub/logic, iterative MUL/DIV/MOD,
// registered result and Z/S/C/V flags with valid/ready on both sides.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ula_operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_t           state_q;
  logic [3:0]       op_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_known;
  logic [3:0]       alu_flags;
  logic             div_zero;

  logic             md_start;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_quo;
  logic [WIDTH-1:0] md_rem;
  logic             md_done;
  logic [WIDTH-1:0] mc_res;
  logic             mc_cv;
  logic [3:0]       mc_flags;

  assign add_sum  = {1'b0, operand1} + {1'b0, operand2};
  assign sub_diff = {1'b0, operand1} - {1'b0, operand2};
  assign div_zero = ((ula_operation == OP_DIV) || (ula_operation == OP_MOD)) &&
                    (operand2 == '0);

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (ula_operation)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_diff[WIDTH-1:0];
        alu_c   = sub_diff[WIDTH];
        alu_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      // Only reached on this path for a zero divisor: result 0 with carry set.
      OP_MUL, OP_DIV, OP_MOD: alu_c = 1'b1;
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOT:  alu_res = ~operand1;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_NAND: alu_res = ~(operand1 & operand2);
      OP_XNOR: alu_res = ~(operand1 ^ operand2);
      default: alu_known = 1'b0;
    endcase

    alu_flags         = '0;
    alu_flags[FLAG_Z] = alu_known && (alu_res == '0);
    alu_flags[FLAG_S] = alu_res[WIDTH-1];
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  assign md_start = (state_q == IDLE) && in_valid &&
                    is_multicycle(ula_operation) && !div_zero;

  ula_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (md_start),
    .is_div     (ula_operation != OP_MUL),
    .a          (operand1),
    .b          (operand2),
    .product_hi (md_hi),
    .product_lo (md_lo),
    .quotient   (md_quo),
    .remainder  (md_rem),
    .done       (md_done)
  );

  always_comb begin
    mc_res = md_quo;
    mc_cv  = 1'b0;
    case (op_q)
      OP_MUL: begin
        mc_res = md_lo;
        mc_cv  = |md_hi;
      end
      OP_MOD:  mc_res = md_rem;
      default: ;
    endcase

    mc_flags         = '0;
    mc_flags[FLAG_Z] = (mc_res == '0);
    mc_flags[FLAG_S] = mc_res[WIDTH-1];
    mc_flags[FLAG_C] = mc_cv;
    mc_flags[FLAG_V] = mc_cv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= ula_operation;
            in_ready <= 1'b0;
            if (md_start) begin
              state_q <= BUSY;
            end else begin
              result    <= alu_res;
              flags     <= alu_flags;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            result    <= mc_res;
            flags     <= mc_flags;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed-vector bench for ula_seq (WIDTH=8) with a queue scoreboard and an
// independent monitor that checks result, flags, latency and hold behaviour.
module tb_ula_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ula_operation;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  bit   mon_seen = 0;

  ula_seq #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ula_operation (ula_operation),
    .operand1      (operand1),
    .operand2      (operand2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .flags         (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; presents one request and records its expectation.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef, input int el);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      ula_operation = op;
      operand1      = a;
      operand2      = b;
      in_valid      = 1'b1;
      sb.push_back('{er, ef, el, cyc});
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: sampled just after the falling edge so out_ready reflects what
  // the DUT will see on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!mon_seen) begin
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          mon_seen = 1'b1;
        end
        check("result", 32'(result), 32'(sb[0].res));
        check("flags", 32'(flags), 32'(sb[0].flg));
        check("in_ready_while_valid", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          mon_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    ula_operation = 4'b0000;
    operand1      = 8'h00;
    operand2      = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // op, a, b, expected result, expected flags {V,C,S,Z}, latency
    issue(4'b0001, 8'h7F, 8'h01, 8'h80, 4'b1010, 1);
    issue(4'b0001, 8'hFF, 8'h01, 8'h00, 4'b0101, 1);
    issue(4'b0010, 8'h00, 8'h01, 8'hFF, 4'b0110, 1);
    issue(4'b0010, 8'h80, 8'h01, 8'h7F, 4'b1000, 1);
    issue(4'b0011, 8'h10, 8'h10, 8'h00, 4'b1101, 9);
    issue(4'b0011, 8'h0C, 8'h0B, 8'h84, 4'b0010, 9);
    issue(4'b0100, 8'h64, 8'h07, 8'h0E, 4'b0000, 9);
    issue(4'b0101, 8'h64, 8'h07, 8'h02, 4'b0000, 9);
    issue(4'b0100, 8'hFF, 8'h01, 8'hFF, 4'b0010, 9);
    issue(4'b0101, 8'hFF, 8'h10, 8'h0F, 4'b0000, 9);
    issue(4'b0100, 8'h64, 8'h00, 8'h00, 4'b0101, 1);
    issue(4'b0101, 8'h33, 8'h00, 8'h00, 4'b0101, 1);
    issue(4'b0110, 8'hF0, 8'h0F, 8'h00, 4'b0001, 1);
    issue(4'b0111, 8'h12, 8'h40, 8'h52, 4'b0000, 1);
    issue(4'b1001, 8'h0F, 8'hAA, 8'hF0, 4'b0010, 1);
    issue(4'b1010, 8'h0F, 8'hF0, 8'h00, 4'b0001, 1);
    issue(4'b1011, 8'hFF, 8'hFF, 8'h00, 4'b0001, 1);
    issue(4'b1100, 8'h0F, 8'h0F, 8'hFF, 4'b0010, 1);
    issue(4'b0000, 8'h12, 8'h34, 8'h00, 4'b0000, 1);
    issue(4'b1111, 8'h00, 8'h00, 8'h00, 4'b0000, 1);

    // Backpressure: result must hold while ignored requests are presented.
    while (!in_ready) @(negedge clk);
    out_ready = 1'b0;
    issue(4'b1000, 8'hF0, 8'hFF, 8'h0F, 4'b0000, 1);
    for (int i = 0; i < 5; i++) begin
      ula_operation = 4'b0001;
      operand1      = 8'h11;
      operand2      = 8'h22;
      in_valid      = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a multiply discards it.
    issue(4'b0011, 8'h10, 8'h10, 8'h00, 4'b1101, 9);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    mon_seen = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_flags", 32'(flags), 32'd0);
    check("midreset_result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postreset_in_ready", 32'(in_ready), 32'd1);
    check("postreset_out_valid", 32'(out_valid), 32'd0);
    issue(4'b0001, 8'h01, 8'h01, 8'h02, 4'b0000, 1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
